// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the arbitrated ALU block: datapath
//               widths, ALU function encodings and requester identifiers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int WIDTH = 32;            // ALU datapath width
  localparam int OPW   = 3;             // function-select width
  localparam int SHW   = $clog2(WIDTH); // in-range shift-amount bits

  localparam logic [OPW-1:0] ALU_ADD = 3'b000;
  localparam logic [OPW-1:0] ALU_SUB = 3'b001;
  localparam logic [OPW-1:0] ALU_SRA = 3'b010;
  localparam logic [OPW-1:0] ALU_SLL = 3'b011;
  localparam logic [OPW-1:0] ALU_SRL = 3'b100;
  localparam logic [OPW-1:0] ALU_AND = 3'b101;
  localparam logic [OPW-1:0] ALU_OR  = 3'b110;
  localparam logic [OPW-1:0] ALU_SLT = 3'b111;

  localparam logic SRC_EXE = 1'b0;      // main execute pipeline
  localparam logic SRC_AGU = 1'b1;      // address/branch helper unit

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_if
// Description : Bundle of the two requester handshakes, the response slot
//               and the grant counters of alu_arbiter.
// Modports    : slave  - arbiter side (consumes requests, drives response)
//               master - environment side (drives requests, takes response)
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if;
  import alu_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_src;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;

  logic [15:0]      gnt_cnt0;
  logic [15:0]      gnt_cnt1;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_src, rsp_result, rsp_zero,
    output gnt_cnt0, gnt_cnt1
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_src, rsp_result, rsp_zero,
    input  gnt_cnt0, gnt_cnt1
  );

endinterface
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_alu
// Description : Purely combinational 32-bit ALU. src1 is treated as signed
//               for arithmetic shift and set-less-than. The shift amount is
//               the full src2 value: amounts >= WIDTH shift everything out.
// Ports       : a_i      - src1
//               b_i      - src2 / shift amount
//               op_i     - function select (ALU_* encodings)
//               result_o - function result
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  wire logic [WIDTH-1:0] a_i,
  input  wire logic [WIDTH-1:0] b_i,
  input  wire logic [OPW-1:0]   op_i,
  output logic      [WIDTH-1:0] result_o
);

  // Any set bit above the in-range shift field means the shift is >= WIDTH.
  logic           shift_big;
  logic [SHW-1:0] shamt;

  assign shift_big = |b_i[WIDTH-1:SHW];
  assign shamt     = b_i[SHW-1:0];

  always_comb begin
    result_o = '0;
    unique case (op_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_SRA: result_o = shift_big ? {WIDTH{a_i[WIDTH-1]}}
                                    : WIDTH'($signed(a_i) >>> shamt);
      ALU_SLL: result_o = shift_big ? '0 : (a_i << shamt);
      ALU_SRL: result_o = shift_big ? '0 : (a_i >> shamt);
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: result_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter sharing one ALU between the execute
//               pipeline (req0) and the address/branch helper (req1).
//               Operands are registered at grant; the ALU sits after the
//               operand registers so the result appears one cycle after the
//               handshake and is held in a single response slot.
// Ports       : clk   - clock, all state on rising edge
//               reset - synchronous active-high reset
//               bus   - requester handshakes, response slot, grant counters
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
(
  input  wire logic    clk,
  input  wire logic    reset,
  alu_arbiter_if.slave bus
);

  logic             valid_q, valid_d;
  logic             src_q,   src_d;
  logic             last_q,  last_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [OPW-1:0]   op_q,    op_d;
  logic [15:0]      cnt0_q,  cnt0_d;
  logic [15:0]      cnt1_q,  cnt1_d;

  logic             slot_free;
  logic             gnt0;
  logic             gnt1;
  logic [WIDTH-1:0] alu_result;

  // The slot can take a new operation when empty or being drained this cycle.
  assign slot_free = !valid_q || bus.rsp_ready;

  // On contention the requester that did not win last time goes next.
  // Grants are masked during reset so requesters never see a false accept.
  assign gnt0 = !reset && slot_free && bus.req0_valid &&
                (!bus.req1_valid || (last_q == SRC_AGU));
  assign gnt1 = !reset && slot_free && bus.req1_valid &&
                (!bus.req0_valid || (last_q == SRC_EXE));

  always_comb begin
    valid_d = valid_q;
    src_d   = src_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    if (gnt0) begin
      valid_d = 1'b1;
      src_d   = SRC_EXE;
      last_d  = SRC_EXE;
      a_d     = bus.req0_a;
      b_d     = bus.req0_b;
      op_d    = bus.req0_op;
      cnt0_d  = cnt0_q + 16'd1;
    end else if (gnt1) begin
      valid_d = 1'b1;
      src_d   = SRC_AGU;
      last_d  = SRC_AGU;
      a_d     = bus.req1_a;
      b_d     = bus.req1_b;
      op_d    = bus.req1_op;
      cnt1_d  = cnt1_q + 16'd1;
    end else if (bus.rsp_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      src_q   <= SRC_EXE;
      last_q  <= SRC_AGU;   // req0 wins the first contention
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= ALU_ADD;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      valid_q <= valid_d;
      src_q   <= src_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  alu_arbiter_alu u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (alu_result)
  );

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp_valid  = valid_q;
  assign bus.rsp_src    = src_q;
  assign bus.rsp_result = alu_result;
  assign bus.rsp_zero   = (alu_result == '0);
  assign bus.gnt_cnt0   = cnt0_q;
  assign bus.gnt_cnt1   = cnt1_q;

  // A requester that is not yet accepted must keep its request unchanged.
  a_req0_hold: assert property (@(posedge clk) disable iff (reset)
    (bus.req0_valid && !bus.req0_ready) |=>
      (bus.req0_valid && $stable(bus.req0_a) && $stable(bus.req0_b) && $stable(bus.req0_op)));

  a_req1_hold: assert property (@(posedge clk) disable iff (reset)
    (bus.req1_valid && !bus.req1_ready) |=>
      (bus.req1_valid && $stable(bus.req1_a) && $stable(bus.req1_b) && $stable(bus.req1_op)));

  a_one_grant: assert property (@(posedge clk) !(bus.req0_ready && bus.req1_ready));

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. A behavioural model of
//               the slot, round-robin winner and grant counters predicts
//               every observable output each cycle; directed sequences
//               cover reset, alternation, backpressure, mid-operation reset
//               and counter wrap, followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit          m_valid;
  bit          m_src;
  int          m_last;      // requester that won most recently
  logic [31:0] m_result;
  logic [15:0] m_cnt0;
  logic [15:0] m_cnt1;

  // Values observed in the most recent cycle
  logic        obs_r0, obs_r1, obs_valid, obs_src, obs_zero;
  logic [31:0] obs_result;
  logic [15:0] obs_cnt0, obs_cnt1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    longint sa = longint'($signed(a));
    longint ua = longint'({32'd0, a});
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return (b >= 32) ? (sa < 0 ? 32'hFFFF_FFFF : 32'h0) : 32'(sa >>> b);
      3'd3: return (b >= 32) ? 32'h0 : 32'(ua << b);
      3'd4: return (b >= 32) ? 32'h0 : 32'(ua >> b);
      3'd5: return a & b;
      3'd6: return a | b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // One clock: check outputs at the falling edge against the model, then
  // advance the model across the rising edge.
  task automatic cycle();
    bit free, g0, g1;
    @(negedge clk);
    free = !m_valid || bus.rsp_ready;
    g0 = !reset && free && bus.req0_valid && (!bus.req1_valid || m_last == 1);
    g1 = !reset && free && bus.req1_valid && (!bus.req0_valid || m_last == 0);
    obs_r0 = bus.req0_ready;   obs_r1 = bus.req1_ready;
    obs_valid = bus.rsp_valid; obs_src = bus.rsp_src;
    obs_result = bus.rsp_result; obs_zero = bus.rsp_zero;
    obs_cnt0 = bus.gnt_cnt0;   obs_cnt1 = bus.gnt_cnt1;
    chk_eq("req0_ready", {31'd0, obs_r0}, {31'd0, g0});
    chk_eq("req1_ready", {31'd0, obs_r1}, {31'd0, g1});
    chk_eq("rsp_valid",  {31'd0, obs_valid}, {31'd0, m_valid});
    chk_eq("rsp_src",    {31'd0, obs_src}, {31'd0, m_src});
    chk_eq("rsp_result", obs_result, m_result);
    chk_eq("rsp_zero",   {31'd0, obs_zero}, {31'd0, (m_result == 32'd0)});
    chk_eq("gnt_cnt0",   {16'd0, obs_cnt0}, {16'd0, m_cnt0});
    chk_eq("gnt_cnt1",   {16'd0, obs_cnt1}, {16'd0, m_cnt1});
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_src = 0; m_last = 1; m_result = 0; m_cnt0 = 0; m_cnt1 = 0;
    end else if (g0) begin
      m_valid = 1; m_src = 0; m_last = 0; m_cnt0 = m_cnt0 + 16'd1;
      m_result = ref_alu(bus.req0_a, bus.req0_b, bus.req0_op);
    end else if (g1) begin
      m_valid = 1; m_src = 1; m_last = 1; m_cnt1 = m_cnt1 + 16'd1;
      m_result = ref_alu(bus.req1_a, bus.req1_b, bus.req1_op);
    end else if (bus.rsp_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
  endtask

  task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
  endtask

  function automatic logic [31:0] rnd_b();
    return ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 40));
  endfunction

  initial begin
    m_valid = 0; m_src = 0; m_last = 1; m_result = 0; m_cnt0 = 0; m_cnt1 = 0;
    reset = 1'b1;
    bus.rsp_ready = 1'b1;
    set_req0(1'b1, 32'd5, 32'd7, ALU_ADD);
    set_req1(1'b1, 32'd9, 32'd9, ALU_SUB);

    // Reset with both requesters valid
    @(posedge clk); #1;
    cycle();
    chk_eq("rst_ready0", {31'd0, obs_r0}, 32'd0);
    chk_eq("rst_ready1", {31'd0, obs_r1}, 32'd0);
    chk_eq("rst_valid",  {31'd0, obs_valid}, 32'd0);
    chk_eq("rst_zero",   {31'd0, obs_zero}, 32'd1);
    cycle();
    reset = 1'b0;

    // Contention: alternate 0,1,0,1 with one result per cycle
    cycle();
    chk_eq("first_gnt0", {31'd0, obs_r0}, 32'd1);
    chk_eq("first_gnt1", {31'd0, obs_r1}, 32'd0);
    cycle();
    chk_eq("alt_gnt1",   {31'd0, obs_r1}, 32'd1);
    chk_eq("add_result", obs_result, 32'd12);
    chk_eq("add_src",    {31'd0, obs_src}, 32'd0);
    chk_eq("add_zero",   {31'd0, obs_zero}, 32'd0);
    chk_eq("add_cnt0",   {16'd0, obs_cnt0}, 32'd1);
    cycle();
    chk_eq("alt_gnt0",   {31'd0, obs_r0}, 32'd1);
    chk_eq("sub_result", obs_result, 32'd0);
    chk_eq("sub_zero",   {31'd0, obs_zero}, 32'd1);
    chk_eq("sub_src",    {31'd0, obs_src}, 32'd1);
    set_req0(1'b1, 32'd3, 32'd4, ALU_ADD);
    cycle();
    chk_eq("alt_gnt1b",  {31'd0, obs_r1}, 32'd1);
    chk_eq("b2b_valid",  {31'd0, obs_valid}, 32'd1);
    set_req1(1'b1, 32'd100, 32'd1, ALU_SLL);
    cycle();
    chk_eq("gnt_3p4",    {31'd0, obs_r0}, 32'd1);

    // Backpressure with req1 pending
    set_req0(1'b0, 32'd0, 32'd0, ALU_ADD);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk_eq("bp_result", obs_result, 32'd7);
      chk_eq("bp_ready1", {31'd0, obs_r1}, 32'd0);
      chk_eq("bp_valid",  {31'd0, obs_valid}, 32'd1);
    end
    bus.rsp_ready = 1'b1;
    cycle();
    chk_eq("bp_release", {31'd0, obs_r1}, 32'd1);
    chk_eq("bp_last7",   obs_result, 32'd7);
    set_req1(1'b0, 32'd0, 32'd0, ALU_ADD);
    cycle();
    chk_eq("bp_new_res", obs_result, 32'd200);
    chk_eq("bp_new_src", {31'd0, obs_src}, 32'd1);

    // Reset while a result is held
    set_req0(1'b1, 32'd1, 32'd1, ALU_ADD);
    cycle();
    chk_eq("mr_gnt", {31'd0, obs_r0}, 32'd1);
    set_req0(1'b0, 32'd0, 32'd0, ALU_ADD);
    bus.rsp_ready = 1'b0;
    cycle();
    chk_eq("mr_held", obs_result, 32'd2);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    chk_eq("mr_valid", {31'd0, obs_valid}, 32'd0);
    chk_eq("mr_cnt0",  {16'd0, obs_cnt0}, 32'd0);
    chk_eq("mr_cnt1",  {16'd0, obs_cnt1}, 32'd0);

    // Randomized traffic; requests change only after acceptance or when idle
    for (int i = 0; i < 1500; i++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) == 0);
      cycle();
      if (!bus.req0_valid || obs_r0) begin
        if ($urandom_range(0, 3) != 0)
          set_req0(1'b1, $urandom(), rnd_b(), 3'($urandom_range(0, 7)));
        else
          bus.req0_valid = 1'b0;
      end
      if (!bus.req1_valid || obs_r1) begin
        if ($urandom_range(0, 3) != 0)
          set_req1(1'b1, $urandom(), rnd_b(), 3'($urandom_range(0, 7)));
        else
          bus.req1_valid = 1'b0;
      end
    end

    // Counter wrap on req1
    reset = 1'b1;
    bus.rsp_ready = 1'b1;
    cycle();
    reset = 1'b0;
    set_req0(1'b1, 32'd2, 32'd2, ALU_OR);
    set_req1(1'b0, 32'd0, 32'd0, ALU_ADD);
    cycle();
    set_req0(1'b0, 32'd0, 32'd0, ALU_ADD);
    set_req1(1'b1, 32'd1, 32'd2, ALU_SLT);
    for (int i = 0; i < 65535; i++) cycle();
    cycle();
    chk_eq("wrap_ffff", {16'd0, obs_cnt1}, 32'h0000_FFFF);
    cycle();
    chk_eq("wrap_zero", {16'd0, obs_cnt1}, 32'd0);
    chk_eq("wrap_cnt0", {16'd0, obs_cnt0}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
